// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory access unit and its lane helper.
package dmem_pkg;

   localparam int BANK_W     = 4;
   localparam int BYTE_OFF_W = 2;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10,
      SZ_X = 2'b11
   } size_e;

   typedef enum logic [2:0] {
      IDLE,
      RD_ISSUE,
      RD_WAIT,
      RMW_WRITE,
      WR_WORD
   } state_e;

   // A request that cannot be served as one naturally aligned access is rejected.
   function automatic logic is_misaligned(input size_e size, input logic [BYTE_OFF_W-1:0] off);
      logic bad;
      bad = 1'b0;
      case (size)
         SZ_B:    bad = 1'b0;
         SZ_H:    bad = off[0];
         SZ_W:    bad = (off != '0);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Combinational byte-lane helper: pulls a load value out of a memory word and
// merges sub-word store data into an existing word.
module dmem_lane_unit
   import dmem_pkg::*;
(
   input  logic [31:0]           word,
   input  logic [BYTE_OFF_W-1:0] off,
   input  size_e                 size,
   input  logic                  sign_ext,
   input  logic [31:0]           wdata,
   output logic [31:0]           load_value,
   output logic [31:0]           merged_word
);

   logic [4:0]  lane_shift;
   logic [31:0] shifted;
   logic [31:0] lane_mask;
   logic [31:0] lane_data;

   assign lane_shift = {off, 3'b000};
   assign shifted    = word >> lane_shift;

   // Load path: bring the addressed lane down to bit 0, then extend it.
   always_comb begin
      load_value = word;
      case (size)
         SZ_B:    load_value = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
         SZ_H:    load_value = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
         default: load_value = word;
      endcase
   end

   // Store path: the memory has no byte enables, so the untouched bytes come from the old word.
   always_comb begin
      lane_mask = 32'hFFFF_FFFF;
      case (size)
         SZ_B:    lane_mask = 32'h0000_00FF << lane_shift;
         SZ_H:    lane_mask = 32'h0000_FFFF << lane_shift;
         default: lane_mask = 32'hFFFF_FFFF;
      endcase
      lane_data   = wdata << lane_shift;
      merged_word = (word & ~lane_mask) | (lane_data & lane_mask);
   end

endmodule

// File: rtl/data_memory_access_unit.sv
// CPU-side initiator for the banked data memory: handshake, address mapping,
// read latency handling and read-modify-write for sub-word stores.
module data_memory_access_unit
   import dmem_pkg::*;
#(
   parameter int BANK_LO    = 18,
   parameter int WORD_AW    = 16,
   parameter int RD_LATENCY = 1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_wr_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_signed_i,
   output logic        resp_valid_o,
   output logic [31:0] resp_rdata_o,
   output logic        resp_err_o,
   output logic [31:0] mem_address_o,
   output logic [31:0] mem_data_o,
   output logic        mem_wren_o,
   input  logic [31:0] mem_data_i
);

   localparam int MEM_BANK_LSB = 18;

   state_e                state;
   logic [BYTE_OFF_W-1:0] off_q;
   size_e                 size_q;
   logic                  sign_q;
   logic                  wr_q;
   logic [31:0]           wdata_q;
   logic [1:0]            wait_cnt;

   size_e                 req_size;
   logic                  req_bad;
   logic [31:0]           mapped_addr;
   logic [31:0]           load_value;
   logic [31:0]           merged_word;
   logic                  unused_addr;

   assign req_size    = size_e'(req_size_i);
   assign req_bad     = is_misaligned(req_size, req_addr_i[BYTE_OFF_W-1:0]);
   assign unused_addr = ^req_addr_i;

   // Bank field and in-bank word index are repacked; every other address bit is zero.
   always_comb begin
      mapped_addr = '0;
      mapped_addr[MEM_BANK_LSB +: BANK_W] = req_addr_i[BANK_LO+2 +: BANK_W];
      mapped_addr[WORD_AW-1:0]            = req_addr_i[WORD_AW+1:2];
   end

   dmem_lane_unit u_lane (
      .word        (mem_data_i),
      .off         (off_q),
      .size        (size_q),
      .sign_ext    (sign_q),
      .wdata       (wdata_q),
      .load_value  (load_value),
      .merged_word (merged_word)
   );

   // Single FSM; every output is registered so resp/ready/wren change only on edges.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state         <= IDLE;
         req_ready_o   <= 1'b1;
         resp_valid_o  <= 1'b0;
         resp_err_o    <= 1'b0;
         resp_rdata_o  <= '0;
         mem_address_o <= '0;
         mem_data_o    <= '0;
         mem_wren_o    <= 1'b0;
         off_q         <= '0;
         size_q        <= SZ_B;
         sign_q        <= 1'b0;
         wr_q          <= 1'b0;
         wdata_q       <= '0;
         wait_cnt      <= '0;
      end else begin
         resp_valid_o <= 1'b0;
         resp_err_o   <= 1'b0;
         mem_wren_o   <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid_i && req_ready_o) begin
                  off_q   <= req_addr_i[BYTE_OFF_W-1:0];
                  size_q  <= req_size;
                  sign_q  <= req_signed_i;
                  wr_q    <= req_wr_i;
                  wdata_q <= req_wdata_i;
                  if (req_bad) begin
                     resp_valid_o <= 1'b1;
                     resp_err_o   <= 1'b1;
                     resp_rdata_o <= '0;
                  end else begin
                     mem_address_o <= mapped_addr;
                     req_ready_o   <= 1'b0;
                     if (req_wr_i && req_size == SZ_W) begin
                        mem_data_o <= req_wdata_i;
                        mem_wren_o <= 1'b1;
                        state      <= WR_WORD;
                     end else begin
                        state <= RD_ISSUE;
                     end
                  end
               end
            end
            RD_ISSUE: begin
               wait_cnt <= 2'(RD_LATENCY - 1);
               state    <= RD_WAIT;
            end
            RD_WAIT: begin
               // mem_data_i is valid on the last wait edge; it feeds both the load and the merge.
               if (wait_cnt == '0) begin
                  if (wr_q) begin
                     mem_data_o <= merged_word;
                     mem_wren_o <= 1'b1;
                     state      <= RMW_WRITE;
                  end else begin
                     resp_valid_o <= 1'b1;
                     resp_rdata_o <= load_value;
                     req_ready_o  <= 1'b1;
                     state        <= IDLE;
                  end
               end else begin
                  wait_cnt <= wait_cnt - 2'd1;
               end
            end
            RMW_WRITE, WR_WORD: begin
               resp_valid_o <= 1'b1;
               resp_rdata_o <= '0;
               req_ready_o  <= 1'b1;
               state        <= IDLE;
            end
            default: begin
               req_ready_o <= 1'b1;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_memory_access_unit.sv
// Self-checking bench: directed and random requests against a word-memory reference model.
module tb_data_memory_access_unit;

   logic        CLK;
   logic        RST;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_wr_i;
   logic [31:0] req_addr_i;
   logic [31:0] req_wdata_i;
   logic [1:0]  req_size_i;
   logic        req_signed_i;
   logic        resp_valid_o;
   logic [31:0] resp_rdata_o;
   logic        resp_err_o;
   logic [31:0] mem_address_o;
   logic [31:0] mem_data_o;
   logic        mem_wren_o;
   logic [31:0] mem_data_i;

   int          tests_run;
   int          fail_count;
   int          wr_count;
   logic [31:0] dev_mem [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];

   data_memory_access_unit dut (
      .CLK           (CLK),
      .RST           (RST),
      .req_valid_i   (req_valid_i),
      .req_ready_o   (req_ready_o),
      .req_wr_i      (req_wr_i),
      .req_addr_i    (req_addr_i),
      .req_wdata_i   (req_wdata_i),
      .req_size_i    (req_size_i),
      .req_signed_i  (req_signed_i),
      .resp_valid_o  (resp_valid_o),
      .resp_rdata_o  (resp_rdata_o),
      .resp_err_o    (resp_err_o),
      .mem_address_o (mem_address_o),
      .mem_data_o    (mem_data_o),
      .mem_wren_o    (mem_wren_o),
      .mem_data_i    (mem_data_i)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [31:0] dev_read(input logic [31:0] a);
      if (dev_mem.exists(a)) return dev_mem[a];
      return init_word(a);
   endfunction

   function automatic logic [31:0] ref_read(input logic [31:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return init_word(a);
   endfunction

   // Memory word address: bank = byte address bits 23:20, word index = bits 17:2.
   function automatic logic [31:0] map_addr(input logic [31:0] a);
      return (((a >> 20) & 32'hF) << 18) | ((a >> 2) & 32'hFFFF);
   endfunction

   // One-cycle read latency memory device.
   always @(posedge CLK) mem_data_i <= dev_read(mem_address_o);

   always @(negedge CLK) begin
      if (mem_wren_o === 1'b1) begin
         dev_mem[mem_address_o] = mem_data_o;
         wr_count++;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         fail_count++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issues one request at the current negedge and checks every cycle until its response.
   task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [1:0] size, input logic sgn);
      logic        err;
      int          lat;
      int          off;
      int          nbits;
      int          wr_before;
      logic [31:0] maddr;
      logic [31:0] old;
      logic [31:0] mask;
      logic [31:0] expv;
      logic [31:0] merged;
      off   = int'(addr & 32'h3);
      err   = (size == 2'd3) || (size == 2'd1 && (off % 2) != 0) || (size == 2'd2 && off != 0);
      maddr = map_addr(addr);
      old   = ref_read(maddr);
      nbits = (size == 2'd0) ? 8 : (size == 2'd1) ? 16 : 32;
      if (nbits == 32) begin
         expv   = old;
         merged = wdata;
      end else begin
         mask   = (32'd1 << nbits) - 32'd1;
         expv   = (old >> (8 * off)) & mask;
         if (sgn && expv >= (32'd1 << (nbits - 1))) expv = expv - (32'd1 << nbits);
         merged = (old & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off));
      end
      if (err || wr) expv = 32'd0;
      lat = err ? 1 : (wr && size == 2'd2) ? 2 : wr ? 4 : 3;

      checkOutput("ready_before_req", req_ready_o, 1);
      req_valid_i  = 1'b1;
      req_wr_i     = wr;
      req_addr_i   = addr;
      req_wdata_i  = wdata;
      req_size_i   = size;
      req_signed_i = sgn;
      wr_before    = wr_count;
      for (int k = 1; k <= lat; k++) begin
         @(negedge CLK);
         if (k == 1) req_valid_i = 1'b0;
         checkOutput("resp_valid", resp_valid_o, (k == lat) ? 1 : 0);
         checkOutput("mem_wren", mem_wren_o, (wr && !err && k == lat - 1) ? 1 : 0);
         if (k < lat) checkOutput("ready_busy", req_ready_o, 0);
         if (!err && k < lat) checkOutput("mem_address", mem_address_o, maddr);
         if (wr && !err && k == lat - 1) checkOutput("mem_data", mem_data_o, merged);
      end
      checkOutput("resp_err", resp_err_o, err);
      checkOutput("resp_rdata", resp_rdata_o, expv);
      checkOutput("ready_after", req_ready_o, 1);
      checkOutput("write_count", wr_count - wr_before, (wr && !err) ? 1 : 0);
      if (wr && !err) ref_mem[maddr] = merged;
   endtask

   initial begin
      logic [31:0] held;
      logic [31:0] raddr;
      int          wr_before;
      tests_run    = 0;
      fail_count   = 0;
      wr_count     = 0;
      RST          = 1'b1;
      req_valid_i  = 1'b0;
      req_wr_i     = 1'b0;
      req_addr_i   = '0;
      req_wdata_i  = '0;
      req_size_i   = '0;
      req_signed_i = 1'b0;

      repeat (2) @(negedge CLK);
      checkOutput("reset_ready", req_ready_o, 1);
      checkOutput("reset_resp_valid", resp_valid_o, 0);
      checkOutput("reset_resp_err", resp_err_o, 0);
      checkOutput("reset_wren", mem_wren_o, 0);
      checkOutput("reset_rdata", resp_rdata_o, 0);
      checkOutput("reset_mem_address", mem_address_o, 0);
      checkOutput("reset_mem_data", mem_data_o, 0);
      RST = 1'b0;
      @(negedge CLK);

      $display("[TB] directed sequence");
      applyStimulus(1'b1, 32'h00FC_0008, 32'hDEAD_BEEF, 2'd2, 1'b0);
      checkOutput("word_store_addr_literal", map_addr(32'h00FC_0008), 32'h003C_0002);
      @(negedge CLK);

      dev_mem[map_addr(32'h0004_000B)] = 32'h8012_3456;
      ref_mem[map_addr(32'h0004_000B)] = 32'h8012_3456;
      applyStimulus(1'b0, 32'h0004_000B, 32'h0, 2'd0, 1'b1);
      checkOutput("byte_signed_literal", resp_rdata_o, 32'hFFFF_FF80);
      applyStimulus(1'b0, 32'h0004_000B, 32'h0, 2'd0, 1'b0);
      checkOutput("byte_unsigned_literal", resp_rdata_o, 32'h0000_0080);
      held = resp_rdata_o;
      repeat (2) @(negedge CLK);
      checkOutput("rdata_hold", resp_rdata_o, held);

      dev_mem[map_addr(32'h0000_0002)] = 32'h1122_3344;
      ref_mem[map_addr(32'h0000_0002)] = 32'h1122_3344;
      applyStimulus(1'b1, 32'h0000_0002, 32'h0000_ABCD, 2'd1, 1'b0);
      checkOutput("half_store_merged", dev_read(32'h0), 32'hABCD_3344);

      applyStimulus(1'b1, 32'h0000_0101, 32'h1234_5678, 2'd2, 1'b0);
      applyStimulus(1'b0, 32'h0000_0103, 32'h0, 2'd1, 1'b1);
      applyStimulus(1'b1, 32'h0000_0100, 32'h5555_5555, 2'd3, 1'b0);

      // Back-to-back: each call starts in the response cycle of the previous one.
      applyStimulus(1'b0, 32'h0010_0004, 32'h0, 2'd2, 1'b0);
      applyStimulus(1'b0, 32'h0010_0006, 32'h0, 2'd1, 1'b1);
      applyStimulus(1'b0, 32'h0010_0005, 32'h0, 2'd0, 1'b0);

      // Reset in the wait cycle of a sub-word store must abort it silently.
      @(negedge CLK);
      wr_before    = wr_count;
      req_valid_i  = 1'b1;
      req_wr_i     = 1'b1;
      req_addr_i   = 32'h0020_0011;
      req_wdata_i  = 32'h0000_0077;
      req_size_i   = 2'd0;
      req_signed_i = 1'b0;
      @(negedge CLK);
      req_valid_i = 1'b0;
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      checkOutput("abort_wren", mem_wren_o, 0);
      checkOutput("abort_resp_valid", resp_valid_o, 0);
      checkOutput("abort_ready", req_ready_o, 1);
      checkOutput("abort_rdata", resp_rdata_o, 0);
      checkOutput("abort_mem_address", mem_address_o, 0);
      checkOutput("abort_mem_data", mem_data_o, 0);
      @(negedge CLK);
      checkOutput("abort_wren_later", mem_wren_o, 0);
      checkOutput("abort_resp_later", resp_valid_o, 0);
      checkOutput("abort_no_write", wr_count - wr_before, 0);

      $display("[TB] random sequence");
      for (int i = 0; i < 60; i++) begin
         raddr = ($urandom & 32'hFF0C_0000) | (32'($urandom_range(0, 3)) << 20)
               | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
         applyStimulus(1'($urandom_range(0, 1)), raddr, $urandom,
                       2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2)),
                       1'($urandom_range(0, 1)));
         if ($urandom_range(0, 2) == 0) @(negedge CLK);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
      $finish;
   end

endmodule
